// File: rtl/video_scanout.sv
// video_scanout -- VGA timing generator and frame-buffer read engine.
//
// Produces 640x480@60 timing and fetches 8-bit BBGGGRRR pixels from a
// 320x240 frame buffer, each source pixel doubled in both directions.
// Position, blanking and sync travel through a delay line so they leave
// the block in the same cycle as the frame-buffer byte they describe.
// The CPU frame select is only sampled on the last clock of a frame, so
// a buffer flip can never tear the picture.
//
// Ports
//   clock, reset_n        pixel clock, async active-low reset
//   frame_address         frame-buffer byte address (shared by both buffers)
//   frame_read_enable     high while the fetched address is in the active area
//   frame_select_request  CPU frame select (MMIO)
//   frame_select_memory   frame-aligned frame select to the compositor
//   pixel_x_pos/y_pos     position aligned with returned pixel data
//   video_active          aligned active-area flag (DAC blanking)
//   hsync_n, vsync_n      aligned syncs, active low
//   frame_start           one-clock pulse with the first pixel of a frame
//
// Optional build macro VIDEO_VBLANK_IRQ_EN adds:
//   vblank_irq_ack (in)   clears vblank_irq
//   vblank_irq     (out)  set at the start of the first blanked line
//
// MEM_LATENCY must lie in 1..3 and be smaller than H_FRONT so delayed
// sync never spills into the next line's active area.

module video_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int FB_WIDTH    = 320,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [16:0] frame_address,
  output logic        frame_read_enable,
  input  logic        frame_select_request,
  output logic        frame_select_memory,
  output logic [9:0]  pixel_x_pos,
  output logic [9:0]  pixel_y_pos,
  output logic        video_active,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start
`ifdef VIDEO_VBLANK_IRQ_EN
  ,
  input  logic        vblank_irq_ack,
  output logic        vblank_irq
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = H_ACTIVE + H_FRONT;
  localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int VS_FIRST = V_ACTIVE + V_FRONT;
  localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

  // Everything that must stay aligned with the pixel byte.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;   // raw sync, active high
    logic       vs;
    logic       sof;  // position (0,0)
  } tag_t;

  logic [9:0] h_cnt, v_cnt;
  logic       h_last, v_last;
  logic       active0;
  logic [16:0] row_base;
  tag_t       tag0;

  // Stage 0 lives in slot 0; slot MEM_LATENCY is the aligned output.
  tag_t [MEM_LATENCY:0] tag_pipe;
  logic [MEM_LATENCY:0] vld_pipe;

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 0: address generation. Dropping bit 0 of each counter doubles
  // every source pixel horizontally and every source row vertically.
  // The row product is a constant multiply, which reduces to shift-add.
  // ---------------------------------------------------------------------
  assign active0  = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign row_base = 17'(v_cnt[9:1]) * 17'(FB_WIDTH);

  always_comb begin
    tag0     = '0;
    tag0.x   = h_cnt;
    tag0.y   = v_cnt;
    tag0.hs  = (h_cnt >= 10'(HS_FIRST)) && (h_cnt < 10'(HS_END));
    tag0.vs  = (v_cnt >= 10'(VS_FIRST)) && (v_cnt < 10'(VS_END));
    tag0.sof = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_address     <= '0;
      frame_read_enable <= 1'b0;
      tag_pipe          <= '0;
      vld_pipe          <= '0;
    end else begin
      // Address holds outside the active area; the enable masks it anyway.
      if (active0) frame_address <= row_base + 17'(h_cnt[9:1]);
      frame_read_enable <= active0;
      tag_pipe <= {tag_pipe[MEM_LATENCY-1:0], tag0};
      vld_pipe <= {vld_pipe[MEM_LATENCY-1:0], active0};
    end
  end

  // Aligned outputs come straight from the last pipe slot, so their reset
  // values are those of a cleared slot (syncs deasserted, no pulse).
  assign pixel_x_pos  = tag_pipe[MEM_LATENCY].x;
  assign pixel_y_pos  = tag_pipe[MEM_LATENCY].y;
  assign video_active = vld_pipe[MEM_LATENCY];
  assign hsync_n      = ~tag_pipe[MEM_LATENCY].hs;
  assign vsync_n      = ~tag_pipe[MEM_LATENCY].vs;
  assign frame_start  = tag_pipe[MEM_LATENCY].sof;

  // ---------------------------------------------------------------------
  // Frame select: only the final clock of a frame can change it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              frame_select_memory <= 1'b0;
    else if (h_last && v_last) frame_select_memory <= frame_select_request;
  end

`ifdef VIDEO_VBLANK_IRQ_EN
  // Set on the first clock of line V_ACTIVE; a coincident ack loses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      vblank_irq <= 1'b0;
    else if ((h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE)))
      vblank_irq <= 1'b1;
    else if (vblank_irq_ack)
      vblank_irq <= 1'b0;
  end
`endif

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Timing and frame-buffer read engine that feeds video_compositor.
- Generates 640x480@60 VGA timing and fetches 8-bit BBGGGRRR pixels from the 320x240 frame buffers, with each source pixel doubled horizontally and vertically.
- Delays position and sync so they arrive aligned with the returned pixel data.
- Latches the CPU frame-select request at frame boundaries so a frame never tears.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch
FB_WIDTH, 320, frame-buffer pixels per row
MEM_LATENCY, 1, frame-buffer read latency in clocks (1..3)

Ports:
clock  input  1  pixel clock (25.175 MHz nominal)
reset_n  input  1  asynchronous, active-low reset
frame_address  output  17  frame-buffer byte address, shared by frame0/frame1
frame_read_enable  output  1  high while address is in the active area
frame_select_request  input  1  CPU-written frame select (MMIO register)
frame_select_memory  output  1  frame-aligned frame select, to the compositor
pixel_x_pos  output  10  delayed horizontal counter, aligned with pixel data
pixel_y_pos  output  10  delayed vertical counter, aligned with pixel data
video_active  output  1  aligned active-area flag, used by the DAC for blanking
hsync_n  output  1  aligned horizontal sync, active low
vsync_n  output  1  aligned vertical sync, active low
frame_start  output  1  one-clock pulse at the first aligned pixel of each frame

Behaviour:
- Reset: asynchronous on reset_n low.
  - Counters h=0, v=0.
  - frame_address=0, frame_read_enable=0, pixel_x_pos=0, pixel_y_pos=0, video_active=0.
  - hsync_n=1, vsync_n=1, frame_start=0, frame_select_memory=0.
  - All delay stages are cleared.
  - Reset asserted mid-line or mid-frame takes effect immediately.
  - After release, the counters restart at (0,0) on the first rising edge.
- Counters, H_TOTAL=800 and V_TOTAL=525:
  - h increments every clock and wraps H_TOTAL-1 -> 0.
  - v increments when h wraps and itself wraps V_TOTAL-1 -> 0.
  - Both are 10-bit and never exceed TOTAL-1.
- Stage 0, registered from the counters:
  - active0 = (h < H_ACTIVE) && (v < V_ACTIVE).
  - frame_address = (v>>1)*FB_WIDTH + (h>>1) when active0, else hold the last value.
  - frame_read_enable = active0.
  - Valid address range is 0..76799. The product may be realised with shift-add; no multiplier is needed.
- Alignment:
  - x, y, active, hsync and vsync pass through a shift register of depth MEM_LATENCY.
  - The outputs for position (h,v) appear exactly MEM_LATENCY clocks after frame_address for (h,v), i.e. in the same cycle pixel_frame0/1 carry that byte.
  - hsync raw = h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = 656..751.
  - vsync raw = v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] = 490..491.
  - Outputs are the inverse of the raw flags.
- frame_start: asserted for one clock when the delayed x=0 and y=0.
- Frame select:
  - frame_select_memory samples frame_select_request only in the clock where h=H_TOTAL-1 and v=V_TOTAL-1.
  - Request changes at any other time are invisible until that clock.
  - A request toggled and restored within one frame produces no change.
- Out-of-range requirement: MEM_LATENCY must be less than H_FRONT so delayed sync never overlaps the next line's active area. Values outside 1..3 are unsupported.

Optional Feature:
- Macro: VIDEO_VBLANK_IRQ_EN.
- When defined, the block adds two ports:
  - input vblank_irq_ack (1 bit).
  - output vblank_irq (1 bit, reset 0).
- vblank_irq sets in the clock after the raw v reaches V_ACTIVE with h=0.
- It stays set until vblank_irq_ack is sampled high.
- Simultaneous set and ack: set wins and the irq stays 1.
- When undefined: neither port exists and no IRQ logic is generated.

Test Plan:
- Reset release, MEM_LATENCY=1 -> cycle 1: frame_address=0, frame_read_enable=1; cycle 2: pixel_x_pos=0, pixel_y_pos=0, video_active=1, frame_start=1; frame_start=0 on the next cycle.
- Address checks -> (h=2,v=1) gives 1; (h=0,v=2) gives 320; (h=639,v=479) gives 76799; frame_read_enable=0 at h=640.
- Line timing -> hsync_n low for exactly 96 clocks, first low cycle aligned with pixel_x_pos=656; video_active low for pixel_x_pos 640..799; vsync_n low only for pixel_y_pos 490..491.
- frame_select_request 0->1 at (h=100,v=200) -> frame_select_memory stays 0 until the clock after (799,524), then reads 1 for the whole next frame.
- Run 420000 clocks -> counters wrap to (0,0) and frame_start pulses once per frame; assert reset_n low at (h=300,v=50) -> all outputs take reset values immediately and restart from (0,0) after release.
- VIDEO_VBLANK_IRQ_EN defined -> vblank_irq rises once per frame at the start of line 480; ack held high in the same cycle as the set leaves it at 1; ack one cycle later clears it.
